// File: rtl/led_fade_scheduler.sv
// Four-bit duty scheduler for a PWM LED dimmer: manual stepping from a key, or an
// automatic up/dwell/down/dwell breathing ramp paced by a step-tick counter.
module led_fade_scheduler #(
  parameter int STEP_TICKS  = 2_500_000,
  parameter int DWELL_STEPS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_step,
  input  logic       key_mode,
  output logic [3:0] duty,
  output logic [1:0] state,
  output logic       tick
);

  localparam int CW = $clog2(STEP_TICKS);
  localparam int DW = $clog2(DWELL_STEPS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STEP_TICKS - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_STEPS - 1);

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_UP     = 2'd1,
    S_DOWN   = 2'd2,
    S_DWELL  = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_duty;
  logic          r_tick;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dwell;
  logic          r_dir;
  logic          r_step_d;
  logic          r_mode_d;

  state_t        w_state_next;
  logic [3:0]    w_duty_next;
  logic          w_tick_next;
  logic [CW-1:0] w_cnt_next;
  logic [DW-1:0] w_dwell_next;
  logic          w_dir_next;
  logic          w_step_rise;
  logic          w_mode_rise;
  logic          w_boundary;

  assign w_step_rise = key_step & ~r_step_d;
  assign w_mode_rise = key_mode & ~r_mode_d;
  assign w_boundary  = (r_state != S_MANUAL) && (r_cnt == CNT_MAX);

  // Delayed key copies reset to 1 so a key held through reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_MANUAL;
      r_duty   <= 4'd0;
      r_tick   <= 1'b0;
      r_cnt    <= '0;
      r_dwell  <= '0;
      r_dir    <= 1'b0;
      r_step_d <= 1'b1;
      r_mode_d <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_duty   <= w_duty_next;
      r_tick   <= w_tick_next;
      r_cnt    <= w_cnt_next;
      r_dwell  <= w_dwell_next;
      r_dir    <= w_dir_next;
      r_step_d <= key_step;
      r_mode_d <= key_mode;
    end
  end

  // A mode edge always wins over a coincident step boundary or step key edge.
  always_comb begin
    w_state_next = r_state;
    if (w_mode_rise) begin
      if (r_state == S_MANUAL) w_state_next = (r_duty == 4'd15) ? S_DOWN : S_UP;
      else                     w_state_next = S_MANUAL;
    end else if (w_boundary) begin
      case (r_state)
        S_UP:    if (r_duty >= 4'd14) w_state_next = S_DWELL;
        S_DOWN:  if (r_duty <= 4'd1)  w_state_next = S_DWELL;
        S_DWELL: if (r_dwell == DWELL_MAX) w_state_next = r_dir ? S_DOWN : S_UP;
        default: w_state_next = r_state;
      endcase
    end
  end

  // r_dir = 1 means the ramp leaves DWELL heading down.
  always_comb begin
    w_duty_next  = r_duty;
    w_tick_next  = 1'b0;
    w_cnt_next   = '0;
    w_dwell_next = r_dwell;
    w_dir_next   = r_dir;
    if (w_mode_rise) begin
      w_dwell_next = '0;
    end else if (r_state == S_MANUAL) begin
      if (w_step_rise) w_duty_next = r_duty + 4'd1;
    end else if (!w_boundary) begin
      w_cnt_next = r_cnt + CW'(1);
    end else begin
      w_tick_next = 1'b1;
      case (r_state)
        S_UP: begin
          if (r_duty != 4'd15) w_duty_next = r_duty + 4'd1;
          if (r_duty >= 4'd14) begin
            w_dir_next   = 1'b1;
            w_dwell_next = '0;
          end
        end
        S_DOWN: begin
          if (r_duty != 4'd0) w_duty_next = r_duty - 4'd1;
          if (r_duty <= 4'd1) begin
            w_dir_next   = 1'b0;
            w_dwell_next = '0;
          end
        end
        S_DWELL: w_dwell_next = (r_dwell == DWELL_MAX) ? '0 : r_dwell + DW'(1);
        default: w_dwell_next = r_dwell;
      endcase
    end
  end

  assign duty  = r_duty;
  assign state = r_state;
  assign tick  = r_tick;

endmodule

// File: tb/tb_led_fade_scheduler.sv
// Bench for led_fade_scheduler with short step/dwell parameters: directed ramp
// scenarios against hand-derived values, then random keys against a reference model.
module tb_led_fade_scheduler;

  localparam int STEP  = 4;
  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_step = 1'b0;
  logic       key_mode = 1'b0;
  logic [3:0] duty;
  logic [1:0] state;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_fade_scheduler #(.STEP_TICKS(STEP), .DWELL_STEPS(DWELL)) dut (
    .clk(clk), .rst(rst), .key_step(key_step), .key_mode(key_mode),
    .duty(duty), .state(state), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 manual, 1 ramping up, 2 ramping down, 3 holding at an end.
  int m_duty, m_mode, m_phase, m_hold;
  bit m_next_up, m_tick, m_prev_s, m_prev_m;

  task automatic model_edge(input bit s, input bit m, input bit r);
    bit sr, mr;
    if (r) begin
      m_duty = 0; m_mode = 0; m_phase = 0; m_hold = 0;
      m_next_up = 0; m_tick = 0; m_prev_s = 1; m_prev_m = 1;
      return;
    end
    sr = s && !m_prev_s;
    mr = m && !m_prev_m;
    m_prev_s = s;
    m_prev_m = m;
    m_tick = 0;
    if (mr) begin
      m_mode  = (m_mode == 0) ? ((m_duty == 15) ? 2 : 1) : 0;
      m_phase = 0;
      m_hold  = 0;
    end else if (m_mode == 0) begin
      if (sr) m_duty = (m_duty + 1) % 16;
    end else begin
      m_phase++;
      if (m_phase == STEP) begin
        m_phase = 0;
        m_tick  = 1;
        if (m_mode == 1) begin
          m_duty++;
          if (m_duty == 15) begin m_mode = 3; m_hold = 0; m_next_up = 0; end
        end else if (m_mode == 2) begin
          m_duty--;
          if (m_duty == 0) begin m_mode = 3; m_hold = 0; m_next_up = 1; end
        end else begin
          m_hold++;
          if (m_hold == DWELL) begin m_mode = m_next_up ? 1 : 2; m_hold = 0; end
        end
      end
    end
  endtask

  // Inputs change at the falling edge; the task returns at the next falling edge.
  task automatic cycle(input logic s, input logic m, input logic r);
    key_step = s;
    key_mode = m;
    rst      = r;
    @(posedge clk);
    model_edge(s, m, r);
    @(negedge clk);
  endtask

  task automatic test_reset;
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    n_checks++; if (duty !== 4'd0)  begin n_fail++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (tick !== 1'b0)  begin n_fail++; $display("FAIL reset_tick: got %0d expected 0", tick); end
    cycle(0, 0, 0);
    n_checks++; if (duty !== 4'd0)  begin n_fail++; $display("FAIL post_reset_duty: got %0d expected 0", duty); end
  endtask

  task automatic test_manual_wrap;
    int ticks_seen = 0;
    int bad_state  = 0;
    for (int i = 1; i <= 17; i++) begin
      cycle(1, 0, 0);
      n_checks++;
      if (duty !== 4'(i % 16)) begin
        n_fail++; $display("FAIL manual_step_%0d: got duty %0d expected %0d", i, duty, i % 16);
      end
      if (tick !== 1'b0) ticks_seen++;
      if (state !== 2'd0) bad_state++;
      cycle(0, 0, 0);
      if (tick !== 1'b0) ticks_seen++;
      if (state !== 2'd0) bad_state++;
    end
    n_checks++; if (ticks_seen != 0) begin n_fail++; $display("FAIL manual_tick: got %0d pulses expected 0", ticks_seen); end
    n_checks++; if (bad_state != 0)  begin n_fail++; $display("FAIL manual_state: got %0d bad cycles expected 0", bad_state); end
  endtask

  task automatic test_up_dwell_down;
    for (int i = 0; i < 13; i++) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    n_checks++; if (duty !== 4'd14) begin n_fail++; $display("FAIL preset_14: got %0d expected 14", duty); end
    cycle(0, 1, 0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL enter_up: got state %0d expected 1", state); end
    n_checks++; if (duty !== 4'd14) begin n_fail++; $display("FAIL enter_up_duty: got %0d expected 14", duty); end
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0);
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL early_tick_%0d: got %0d expected 0", i, tick); end
    end
    cycle(0, 0, 0);
    n_checks++; if (tick !== 1'b1)  begin n_fail++; $display("FAIL first_tick: got %0d expected 1", tick); end
    n_checks++; if (duty !== 4'd15) begin n_fail++; $display("FAIL top_duty: got %0d expected 15", duty); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL top_dwell: got state %0d expected 3", state); end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL still_dwell: got state %0d expected 3", state); end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL enter_down: got state %0d expected 2", state); end
    n_checks++; if (duty !== 4'd15) begin n_fail++; $display("FAIL dwell_duty: got %0d expected 15", duty); end
    for (int d = 14; d >= 13; d--) begin
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
      n_checks++; if (duty !== 4'(d)) begin n_fail++; $display("FAIL down_duty: got %0d expected %0d", duty, d); end
    end
  endtask

  task automatic test_bottom_dwell;
    for (int d = 12; d >= 1; d--) for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    n_checks++; if (duty !== 4'd1)  begin n_fail++; $display("FAIL pre_bottom: got %0d expected 1", duty); end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pre_bottom_state: got %0d expected 2", state); end
    for (int i = 0; i < 4; i++) cycle(i[0] ? 1'b0 : 1'b1, 0, 0);
    n_checks++; if (duty !== 4'd0)  begin n_fail++; $display("FAIL bottom_duty: got %0d expected 0", duty); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL bottom_dwell: got state %0d expected 3", state); end
    for (int i = 0; i < 8; i++) cycle(i[0] ? 1'b0 : 1'b1, 0, 0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL reenter_up: got state %0d expected 1", state); end
    n_checks++; if (duty !== 4'd0)  begin n_fail++; $display("FAIL dwell_step_ignored: got %0d expected 0", duty); end
    for (int i = 0; i < 4; i++) cycle(i[0] ? 1'b0 : 1'b1, 0, 0);
    n_checks++; if (duty !== 4'd1)  begin n_fail++; $display("FAIL up_step_ignored: got %0d expected 1", duty); end
  endtask

  task automatic test_same_edge;
    cycle(0, 1, 0);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL exit_manual: got state %0d expected 0", state); end
    cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    n_checks++; if (duty !== 4'd5) begin n_fail++; $display("FAIL preset_5: got %0d expected 5", duty); end
    cycle(1, 1, 0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL same_edge_state: got %0d expected 1", state); end
    n_checks++; if (duty !== 4'd5)  begin n_fail++; $display("FAIL same_edge_duty: got %0d expected 5", duty); end
  endtask

  task automatic test_reset_mid_ramp;
    int bad = 0;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    n_checks++; if (duty !== 4'd6) begin n_fail++; $display("FAIL ramp_duty: got %0d expected 6", duty); end
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    n_checks++; if (duty !== 4'd0)  begin n_fail++; $display("FAIL midramp_rst_duty: got %0d expected 0", duty); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL midramp_rst_state: got %0d expected 0", state); end
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0);
      if (duty !== 4'd0 || state !== 2'd0 || tick !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL held_keys: got %0d bad cycles expected 0", bad); end
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    n_checks++; if (duty !== 4'd1)  begin n_fail++; $display("FAIL rearm_step: got %0d expected 1", duty); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rearm_state: got %0d expected 0", state); end
    cycle(0, 0, 0);
  endtask

  task automatic test_dwell_exit;
    for (int i = 0; i < 13; i++) begin cycle(1, 0, 0); cycle(0, 0, 0); end
    cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL in_dwell: got state %0d expected 3", state); end
    cycle(0, 1, 0);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL dwell_exit_state: got %0d expected 0", state); end
    n_checks++; if (duty !== 4'd15) begin n_fail++; $display("FAIL dwell_exit_duty: got %0d expected 15", duty); end
    n_checks++; if (tick !== 1'b0)  begin n_fail++; $display("FAIL dwell_exit_tick: got %0d expected 0", tick); end
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    n_checks++; if (duty !== 4'd0) begin n_fail++; $display("FAIL wrap_after_dwell: got %0d expected 0", duty); end
    cycle(0, 0, 0);
  endtask

  task automatic test_random;
    logic ks = 1'b0;
    logic km = 1'b0;
    logic r;
    cycle(0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0)  ks = ~ks;
      if ($urandom_range(0, 79) == 0) km = ~km;
      r = ($urandom_range(0, 499) == 0);
      cycle(ks, km, r);
      n_checks++;
      if (duty !== 4'(m_duty)) begin n_fail++; $display("FAIL rand_duty cyc %0d: got %0d expected %0d", i, duty, m_duty); end
      n_checks++;
      if (state !== 2'(m_mode)) begin n_fail++; $display("FAIL rand_state cyc %0d: got %0d expected %0d", i, state, m_mode); end
      n_checks++;
      if (tick !== m_tick) begin n_fail++; $display("FAIL rand_tick cyc %0d: got %0d expected %0d", i, tick, m_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_manual_wrap();
    test_up_dwell_down();
    test_bottom_dwell();
    test_same_edge();
    test_reset_mid_ramp();
    test_dwell_exit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
